// File: rtl/stream_packer.sv
// Packs RATIO narrow words into one wide word with per-lane keep bits.
// Packets may end early on in_last; partial words are zero-padded above the last lane.
module stream_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clear,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int unsigned OUT_WIDTH = DATA_WIDTH * RATIO;
    localparam int unsigned LB_RATIO  = $clog2(RATIO);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_t;

    out_state_t              r_state;
    out_state_t              w_state_next;
    logic [OUT_WIDTH-1:0]    r_acc_data;
    logic [RATIO-1:0]        r_acc_keep;
    logic [LB_RATIO-1:0]     r_idx;
    logic [OUT_WIDTH-1:0]    r_out_data;
    logic [RATIO-1:0]        r_out_keep;
    logic                    r_out_last;

    logic                    w_in_ready;
    logic                    w_in_exec;
    logic                    w_out_exec;
    logic                    w_complete;
    logic [OUT_WIDTH-1:0]    w_merge_data;
    logic [RATIO-1:0]        w_merge_keep;

    assign w_in_ready = (r_state == S_EMPTY || out_ready) && !clear;
    assign w_in_exec  = in_valid && w_in_ready;
    assign w_out_exec = (r_state == S_FULL) && out_ready;
    assign w_complete = w_in_exec && (in_last || r_idx == LB_RATIO'(RATIO - 1));

    // Accumulator contents with the incoming word dropped into lane idx.
    always_comb begin
        w_merge_data = r_acc_data;
        w_merge_keep = r_acc_keep;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (LB_RATIO'(k) == r_idx) begin
                w_merge_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                w_merge_keep[k]                          = 1'b1;
            end
        end
    end

    // Output register occupancy.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_complete) w_state_next = S_FULL;
                S_FULL:  if (w_out_exec && !w_complete) w_state_next = S_EMPTY;
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lane accumulator; emptied whenever its contents move to the output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc_data <= '0;
            r_acc_keep <= '0;
            r_idx      <= '0;
        end else if (clear || w_complete) begin
            r_acc_data <= '0;
            r_acc_keep <= '0;
            r_idx      <= '0;
        end else if (w_in_exec) begin
            r_acc_data <= w_merge_data;
            r_acc_keep <= w_merge_keep;
            r_idx      <= r_idx + LB_RATIO'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_data <= '0;
            r_out_keep <= '0;
            r_out_last <= 1'b0;
        end else if (clear) begin
            r_out_data <= '0;
            r_out_keep <= '0;
            r_out_last <= 1'b0;
        end else if (w_complete) begin
            r_out_data <= w_merge_data;
            r_out_keep <= w_merge_keep;
            r_out_last <= in_last;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer (DATA_WIDTH=8, RATIO=4): directed cases plus random traffic
// against a queue-based packet model; a separate monitor pops expectations on every output transfer.
module tb_stream_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned RT = 4;

    typedef struct {
        logic [DW*RT-1:0] data;
        logic [RT-1:0]    keep;
        logic             last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              clear = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [DW*RT-1:0]  out_data;
    logic [RT-1:0]     out_keep;
    logic              out_last;
    logic              out_valid;
    logic              out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    logic [DW-1:0] grp[$];
    exp_t          exp_q[$];

    stream_packer #(.DATA_WIDTH(DW), .RATIO(RT)) dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect words of a group, emit when full or at packet end.
    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        exp_t e;
        grp.push_back(d);
        if (grp.size() == RT || l) begin
            e.data = '0;
            for (int i = 0; i < grp.size(); i++) e.data = e.data | ((DW*RT)'(grp[i]) << (DW * i));
            e.keep = RT'((1 << grp.size()) - 1);
            e.last = l;
            exp_q.push_back(e);
            grp.delete();
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic ordy, input logic clr);
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; in_last = l; out_ready = ordy; clear = clr;
        @(negedge clk);
        if (rstn) begin
            if (clear) begin
                grp.delete();
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                n_acc++;
                model_accept(in_data, in_last);
            end
        end
    endtask

    // Monitor: handshake rule, hold stability and scoreboard comparison.
    logic             prev_hold = 1'b0;
    logic [DW*RT-1:0] prev_data;
    logic [RT-1:0]    prev_keep;
    logic             prev_last;
    always @(negedge clk) begin
        if (rstn && !clear) begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (prev_hold && out_valid) begin
                check("hold_data", 64'(out_data), 64'(prev_data));
                check("hold_keep", 64'(out_keep), 64'(prev_keep));
                check("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no word at %0t", out_data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_data", 64'(out_data), 64'(e.data));
                    check("sb_keep", 64'(out_keep), 64'(e.keep));
                    check("sb_last", 64'(out_last), 64'(e.last));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
            prev_last = out_last;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        int acc0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #11 rstn = 1'b1;

        // Full group of four.
        step(1, 8'h11, 0, 1, 0);
        step(1, 8'h22, 0, 1, 0);
        step(1, 8'h33, 0, 1, 0);
        step(1, 8'h44, 0, 1, 0);
        check("full_valid_early", 64'(out_valid), 64'd0);
        step(0, 8'h00, 0, 1, 0);
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_data", 64'(out_data), 64'h44332211);
        check("full_keep", 64'(out_keep), 64'hF);
        check("full_last", 64'(out_last), 64'd0);

        // Short packet, then restart at lane 0.
        step(1, 8'hA1, 0, 1, 0);
        step(1, 8'hA2, 1, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        check("short_data", 64'(out_data), 64'h0000A2A1);
        check("short_keep", 64'(out_keep), 64'h3);
        check("short_last", 64'(out_last), 64'd1);
        step(1, 8'h55, 1, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        check("restart_data", 64'(out_data), 64'h00000055);
        check("restart_keep", 64'(out_keep), 64'h1);

        // Continuous stream, no bubbles.
        acc0 = n_acc;
        for (int i = 0; i < 16; i++) step(1, DW'(i), 0, 1, 0);
        check("stream_accepts", 64'(n_acc - acc0), 64'd16);
        step(0, 8'h00, 0, 1, 0);
        check("stream_last_word", 64'(out_data), 64'h0F0E0D0C);

        // Backpressure on a pending word.
        for (int i = 0; i < 4; i++) step(1, DW'(8'h60 + i), 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h99, 0, 0, 0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_valid", 64'(out_valid), 64'd1);
        end
        check("bp_data", 64'(out_data), 64'h63626160);
        step(0, 8'h00, 0, 1, 0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);

        // Clear mid-group drops partial and concurrent words.
        step(1, 8'hC1, 0, 1, 0);
        step(1, 8'hC2, 0, 1, 0);
        step(1, 8'hC3, 0, 1, 0);
        step(1, 8'hC4, 0, 1, 1);
        step(0, 8'h00, 0, 1, 0);
        check("clear_valid", 64'(out_valid), 64'd0);
        for (int i = 1; i <= 4; i++) step(1, DW'(i), 0, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        check("clear_next_data", 64'(out_data), 64'h04030201);

        // Asynchronous reset mid-packet.
        step(1, 8'hD1, 0, 1, 0);
        step(1, 8'hD2, 0, 1, 0);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        grp.delete();
        exp_q.delete();
        in_valid = 1'b0;
        #7 rstn = 1'b1;
        step(0, 8'h00, 0, 1, 0);
        check("arst_no_emit", 64'(out_valid), 64'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
        end

        // Close any open group and drain with a bounded wait.
        begin
            int guard;
            guard = 0;
            while (grp.size() != 0 && guard < 20) begin
                step(1, 8'hEE, 1, 1, 0);
                guard++;
            end
            guard = 0;
            while (exp_q.size() != 0 && guard < 20) begin
                step(0, 8'h00, 0, 1, 0);
                guard++;
            end
            step(0, 8'h00, 0, 1, 0);
            check("drain_queue", 64'(exp_q.size()), 64'd0);
            check("drain_valid", 64'(out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one input word (matches upstream interleaved FIFO out_data).
REQ-002 Parameter RATIO, default 4, input words packed per output word; SHALL be a power of two, >= 2.
REQ-003 Derived constants: OUT_WIDTH = DATA_WIDTH*RATIO; LB_RATIO = $clog2(RATIO).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous flush of all held data.
REQ-007 in_data  input  DATA_WIDTH  narrow word from the upstream FIFO.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_last  input  1  word ends a packet; qualified by in_valid.
REQ-010 in_ready  output  1  packer accepts in_data this cycle.
REQ-011 out_data  output  OUT_WIDTH  packed word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 out_keep  output  RATIO  lane k holds a valid word.
REQ-013 out_last  output  1  packed word ends a packet.
REQ-014 out_valid  output  1  out_data, out_keep and out_last valid.
REQ-015 out_ready  input  1  downstream accepts the packed word.

Function
REQ-016 Input transfer (in_exec) SHALL occur when in_valid and in_ready are both 1; output transfer (out_exec) when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (!out_valid | out_ready) and SHALL be low while clear is 1.
REQ-018 Lane index idx (LB_RATIO bits, reset 0) SHALL select the accumulator lane written on in_exec; the first word of a group goes to lane 0 (LSBs).
REQ-019 On in_exec with idx < RATIO-1 and in_last=0: write lane idx, set its keep bit, idx <= idx+1.
REQ-020 On in_exec with idx = RATIO-1 or in_last=1 (completion): load output register with the accumulator including the current word; set out_keep, out_last <= in_last, out_valid <= 1; clear accumulator data and keep to 0; idx <= 0.
REQ-021 Unused lanes of a partial word SHALL be 0 with their keep bits 0; out_keep SHALL always be a contiguous run of ones starting at lane 0.
REQ-022 Latency: a completed packed word SHALL appear on out_valid the cycle after the completing in_exec.
REQ-023 Output register state machine: EMPTY (out_valid=0) -> FULL on completion; FULL -> EMPTY on out_exec without completion; FULL stays FULL when out_exec and completion coincide (new word loaded, no bubble).
REQ-024 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Sustained in_valid=1 and out_ready=1 SHALL give one input word per cycle and one packed word every RATIO cycles.
REQ-026 clear=1 SHALL, at the next edge, zero accumulator, keep, idx, out_valid, out_keep, out_last and out_data; clear takes priority over any simultaneous in_exec or out_exec, and words presented in that cycle are dropped.

Reset
REQ-027 On rstn=0, asynchronously: out_valid=0, out_data=0, out_keep=0, out_last=0, idx=0, accumulator=0; in_ready then reads 1.
REQ-028 Reset asserted mid-packet SHALL discard partial and pending words without emitting them.

Structure
REQ-029 No shared package; constants are module-local.
REQ-030 Single module, no sub-modules; the accumulator and output register are plain flops.

Verification (DATA_WIDTH=8, RATIO=4)
REQ-031 Inputs 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1 -> one cycle after 0x44: out_data=0x44332211, out_keep=4'b1111, out_last=0.
REQ-032 Inputs 0xA1,0xA2 with in_last on 0xA2 -> out_data=0x0000A2A1, out_keep=4'b0011, out_last=1; the next word restarts at lane 0.
REQ-033 Continuous input 0x00..0x0F with out_ready=1 -> 16 in_execs in 16 cycles, 4 packed words 0x03020100 .. 0x0F0E0D0C, no bubble.
REQ-034 Packed word pending with out_ready=0 for 5 cycles -> in_ready=0 and out fields stable; out_ready=1 -> out_exec, in_ready high in the same cycle.
REQ-035 Three words accepted, then clear=1 together with in_valid -> no output; the next four words 0x01..0x04 produce 0x04030201.
REQ-036 rstn pulsed low after two words, asynchronously to clk -> out_valid=0 immediately, in_ready=1; the partial word is never emitted.
